// File: rtl/sdc_block_write_seq.sv
// SD-card (SPI mode) single-block write data phase sequencer.
// Runs after CMD24 has been acknowledged. It sends the 0xFE start token, BLOCK_BYTES data bytes
// pulled from an upstream valid/ready byte source, and the CRC16 of those bytes. It then collects
// the card's data-response token and waits out card busy. One MOSI bit advances per tick strobe.
// Ports:
//   clk, resetN          system clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a block write when idle
//   tick                 one-cycle bit strobe from the SCLK generator
//   dataIn/dataValid     upstream byte and its valid flag
//   dataReady            sequencer can take a byte (transfer on dataValid & dataReady)
//   mosi, miso, csN      SPI data out, data in (sampled on tick), active-low card select
//   busy, done           operation in progress, one-cycle completion pulse
//   errCode              0 ok, 1 underrun, 2 response timeout, 3 rejected, 4 busy timeout
//   respStatus           sss field of the data-response token
module sdc_block_write_seq #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned RESP_WAIT_BITS = 64,
  parameter int unsigned BUSY_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       tick,
  input  logic [7:0] dataIn,
  input  logic       dataValid,
  output logic       dataReady,
  output logic       mosi,
  input  logic       miso,
  output logic       csN,
  output logic       busy,
  output logic       done,
  output logic [2:0] errCode,
  output logic [2:0] respStatus
);

  localparam int unsigned TotalBits = 8 + 8 * BLOCK_BYTES + 16;
  localparam int unsigned BitW      = $clog2(TotalBits + 1);
  localparam int unsigned FetchW    = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned WaitMax   = (RESP_WAIT_BITS > BUSY_TIMEOUT) ? RESP_WAIT_BITS
                                                                      : BUSY_TIMEOUT;
  localparam int unsigned WaitW     = $clog2(WaitMax + 1);

  localparam logic [BitW-1:0]   DataLast = BitW'(8 * BLOCK_BYTES - 1);
  localparam logic [BitW-1:0]   CrcLast  = BitW'(15);
  localparam logic [BitW-1:0]   RespLast = BitW'(3);
  localparam logic [FetchW-1:0] FetchMax = FetchW'(BLOCK_BYTES);
  localparam logic [WaitW-1:0]  RespMax  = WaitW'(RESP_WAIT_BITS);
  localparam logic [WaitW-1:0]  BusyMax  = WaitW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StToken, StData, StCrc, StResp, StBusy, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [FetchW-1:0]   fetched_q, fetched_d;
  logic [15:0]         crc_q, crc_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                resp_started_q, resp_started_d;
  logic [2:0]          resp_sh_q, resp_sh_d;
  logic [2:0]          err_q, err_d;
  logic [2:0]          status_q, status_d;

  logic                xfer;
  logic                boundary;
  logic [15:0]         crc_step;
  logic [WaitW-1:0]    wait_inc;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    fetched_d      = fetched_q;
    crc_d          = crc_q;
    wait_d         = wait_q;
    resp_started_d = resp_started_q;
    resp_sh_d      = resp_sh_q;
    err_d          = err_q;
    status_d       = status_q;
    boundary       = 1'b0;
    mosi           = 1'b1;
    csN            = (state_q == StIdle) || (state_q == StDone);
    busy           = !csN;
    done           = (state_q == StDone);
    dataReady      = ((state_q == StToken) || (state_q == StData)) && !hold_vld_q &&
                     (fetched_q != FetchMax);
    xfer           = dataReady && dataValid;
    wait_inc       = wait_q + WaitW'(1);
    // CRC16-CCITT, MSB first, fed with the bit currently on MOSI
    crc_step       = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ shift_q[7]) ? 16'h1021 : 16'h0000);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StToken;
          bit_cnt_d      = '0;
          crc_d          = '0;
          err_d          = '0;
          status_d       = '0;
          fetched_d      = '0;
          hold_vld_d     = 1'b0;
          wait_d         = '0;
          resp_started_d = 1'b0;
        end
      end
      StToken: begin
        mosi = (bit_cnt_q[2:0] != 3'd7);  // 0xFE, MSB first
        if (tick) begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q[2:0] == 3'd7) begin
            state_d   = StData;
            bit_cnt_d = '0;
            boundary  = 1'b1;
          end
        end
      end
      StData: begin
        mosi = shift_q[7];
        if (tick) begin
          shift_d   = {shift_q[6:0], 1'b0};
          crc_d     = crc_step;
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == DataLast) begin
            state_d   = StCrc;
            bit_cnt_d = '0;
          end else if (bit_cnt_q[2:0] == 3'd7) begin
            boundary = 1'b1;
          end
        end
      end
      StCrc: begin
        mosi = crc_q[15];
        if (tick) begin
          crc_d     = {crc_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == CrcLast) begin
            state_d   = StResp;
            bit_cnt_d = '0;
            wait_d    = '0;
          end
        end
      end
      StResp: begin
        if (tick) begin
          if (!resp_started_q) begin
            if (!miso) begin
              resp_started_d = 1'b1;
              bit_cnt_d      = '0;
            end else begin
              wait_d = wait_inc;
              if (wait_inc == RespMax) begin
                err_d   = 3'd2;
                state_d = StDone;
              end
            end
          end else if (bit_cnt_q == RespLast) begin
            // Trailing bit of the token: its value is not used
            status_d = resp_sh_q;
            wait_d   = '0;
            if (resp_sh_q == 3'b010) begin
              state_d = StBusy;
            end else begin
              err_d   = 3'd3;
              state_d = StDone;
            end
          end else begin
            resp_sh_d = {resp_sh_q[1:0], miso};
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StBusy: begin
        if (tick) begin
          if (miso) begin
            state_d = StDone;
          end else begin
            wait_d = wait_inc;
            if (wait_inc == BusyMax) begin
              err_d   = 3'd4;
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d    = StIdle;
        hold_vld_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Holding buffer hands its byte to the shift register at each byte boundary; the freed
    // slot may be refilled in the same cycle.
    if (boundary) begin
      if (hold_vld_q) begin
        shift_d    = hold_q;
        hold_vld_d = 1'b0;
      end else begin
        err_d   = 3'd1;
        state_d = StDone;
      end
    end
    if (xfer) begin
      hold_d     = dataIn;
      hold_vld_d = 1'b1;
      fetched_d  = fetched_q + FetchW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      fetched_q      <= '0;
      crc_q          <= '0;
      wait_q         <= '0;
      resp_started_q <= 1'b0;
      resp_sh_q      <= '0;
      err_q          <= '0;
      status_q       <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      fetched_q      <= fetched_d;
      crc_q          <= crc_d;
      wait_q         <= wait_d;
      resp_started_q <= resp_started_d;
      resp_sh_q      <= resp_sh_d;
      err_q          <= err_d;
      status_q       <= status_d;
    end
  end

  assign errCode    = err_q;
  assign respStatus = status_q;

endmodule

// File: tb/tb_sdc_block_write_seq.sv
// Directed testbench for sdc_block_write_seq: full good block, throttled source, underrun,
// rejected response, response timeout, busy timeout, and reset mid-block followed by a clean run.
module tb_sdc_block_write_seq;

  localparam int unsigned BB    = 512;
  localparam int unsigned RW    = 64;
  localparam int unsigned BT    = 100;
  localparam int          TOTAL = 8 + 8 * BB + 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       dataValid = 1'b0;
  logic       miso = 1'b1;
  logic       dataReady, mosi, csN, busy, done;
  logic [2:0] errCode, respStatus;

  always #5 clk = ~clk;

  sdc_block_write_seq #(
    .BLOCK_BYTES   (BB),
    .RESP_WAIT_BITS(RW),
    .BUSY_TIMEOUT  (BT)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .tick      (tick),
    .dataIn    (dataIn),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .mosi      (mosi),
    .miso      (miso),
    .csN       (csN),
    .busy      (busy),
    .done      (done),
    .errCode   (errCode),
    .respStatus(respStatus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-run stimulus configuration
  bit cfg_ff;
  int cfg_limit;
  bit cfg_toggle;
  int cfg_div;
  bit seq_bits[$];
  bit miso_tail;
  int mark_rx;
  int mark_tx;
  int abort_tx;

  // Per-run observations
  int         cyc, tx_cnt, rx_cnt, src_idx, done_cnt, done_cyc, mark_cyc, mark_tx_cyc;
  bit         tx_bits[TOTAL];
  logic [2:0] err_at_done, stat_at_done;
  logic       first_rx_mosi;
  bit         aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] tx_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = tx_bits[base+i];
    return b;
  endfunction

  function automatic logic [15:0] crc_model(input bit ff);
    logic [15:0] c = 16'h0000;
    logic [7:0]  b;
    logic        fb;
    for (int k = 0; k < BB; k++) begin
      b = ff ? 8'hFF : k[7:0];
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic check_stream(input logic [15:0] want_crc);
    int         bad = 0;
    logic [7:0] want;
    check("token", tx_byte(0), 8'hFE);
    for (int k = 0; k < BB; k++) begin
      want = cfg_ff ? 8'hFF : k[7:0];
      if (tx_byte(8 + 8 * k) !== want) bad++;
    end
    check("data_bytes_bad", bad, 0);
    check("crc", {tx_byte(8 + 8 * BB), tx_byte(16 + 8 * BB)}, want_crc);
  endtask

  task automatic run_block(input int budget);
    bit finished = 1'b0;
    bit start_pulsed = 1'b0;
    cyc = 0; tx_cnt = 0; rx_cnt = 0; src_idx = 0; done_cnt = 0;
    done_cyc = -1000; mark_cyc = -100; mark_tx_cyc = -100; aborted = 1'b0;
    err_at_done = 3'bxxx; stat_at_done = 3'bxxx; first_rx_mosi = 1'bx;
    @(posedge clk); #1;
    start = 1'b1; tick = 1'b0; dataValid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_accept", {busy, csN}, 2'b10);
    while (!finished && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      tick      = (cyc % cfg_div) == 0;
      start     = (tx_cnt == 50) && !start_pulsed;  // must be ignored mid-block
      dataValid = (src_idx < cfg_limit) && (!cfg_toggle || cyc[0]);
      dataIn    = cfg_ff ? 8'hFF : src_idx[7:0];
      if (tick && tx_cnt >= TOTAL)
        miso = (rx_cnt < seq_bits.size()) ? seq_bits[rx_cnt] : miso_tail;
      @(negedge clk);
      if (start) start_pulsed = 1'b1;
      if (dataValid && dataReady) src_idx++;
      if (tick) begin
        if (tx_cnt < TOTAL) begin
          if (tx_cnt == abort_tx) begin
            resetN = 1'b0;
            #1;
            check("rst_mosi", mosi, 1'b1);
            check("rst_csn", csN, 1'b1);
            check("rst_busy_done_ready", {busy, done, dataReady}, 3'b000);
            check("rst_err_status", {errCode, respStatus}, 6'd0);
            aborted  = 1'b1;
            finished = 1'b1;
          end
          tx_bits[tx_cnt] = mosi;
          if (tx_cnt == mark_tx) mark_tx_cyc = cyc;
          tx_cnt++;
        end else begin
          if (rx_cnt == 0) first_rx_mosi = mosi;
          if (rx_cnt == mark_rx) mark_cyc = cyc;
          rx_cnt++;
        end
      end
      if (!aborted && done) begin
        done_cnt++;
        done_cyc     = cyc;
        err_at_done  = errCode;
        stat_at_done = respStatus;
        check("done_csn_busy_ready", {csN, busy, dataReady}, 3'b100);
        tick = 1'b0; dataValid = 1'b0; start = 1'b1;  // start in the DONE cycle is ignored
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("after_done", {csN, busy, done}, 3'b100);
        finished = 1'b1;
      end
    end
    tick = 1'b0; dataValid = 1'b0; start = 1'b0;
    if (!aborted) check("done_seen", done_cnt, 1);
  endtask

  task automatic cfg_good(input bit ff, input bit toggle, input int div);
    cfg_ff = ff; cfg_limit = BB; cfg_toggle = toggle; cfg_div = div;
    seq_bits = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    miso_tail = 1'b1; mark_rx = 18; mark_tx = -1; abort_tx = -1;
  endtask

  initial begin
    #1;
    check("reset_mosi_csn", {mosi, csN}, 2'b11);
    check("reset_busy_done_ready", {busy, done, dataReady}, 3'b000);
    check("reset_err_status", {errCode, respStatus}, 6'd0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // Good block of 0xFF, tick every clock, OK response then 10 busy ticks
    cfg_good(1'b1, 1'b0, 1);
    run_block(6000);
    check_stream(16'h7FA1);
    check("t1_err", err_at_done, 3'd0);
    check("t1_status", stat_at_done, 3'b010);
    check("t1_done_lat", done_cyc - mark_cyc, 1);
    check("t1_resp_mosi", first_rx_mosi, 1'b1);
    check("t1_bytes", src_idx, BB);

    // Incrementing data, dataValid toggling, tick every 4 clocks
    cfg_good(1'b0, 1'b1, 4);
    run_block(20000);
    check_stream(crc_model(1'b0));
    check("t2_err", err_at_done, 3'd0);
    check("t2_status", stat_at_done, 3'b010);
    check("t2_done_lat", done_cyc - mark_cyc, 1);

    // Only 10 bytes available: underrun at the byte-10 boundary (tx tick 87)
    cfg_good(1'b0, 1'b0, 1);
    cfg_limit = 10; mark_tx = 8 + 80 - 1;
    run_block(500);
    check("t3_err", err_at_done, 3'd1);
    check("t3_bytes", src_idx, 10);
    check("t3_lat_le2", (done_cyc - mark_tx_cyc >= 1) && (done_cyc - mark_tx_cyc <= 2), 1'b1);

    // Rejected: status 101, no busy wait (tail 0 would otherwise stall)
    cfg_good(1'b1, 1'b0, 1);
    seq_bits = '{1, 1, 0, 1, 0, 1, 1}; miso_tail = 1'b0; mark_rx = 6;
    run_block(6000);
    check("t4_err", err_at_done, 3'd3);
    check("t4_status", stat_at_done, 3'b101);
    check("t4_done_lat", done_cyc - mark_cyc, 1);

    // No response start bit within RW ticks
    cfg_good(1'b1, 1'b0, 1);
    seq_bits = {}; miso_tail = 1'b1; mark_rx = RW - 1;
    run_block(6000);
    check("t5_err", err_at_done, 3'd2);
    check("t5_status", stat_at_done, 3'd0);
    check("t5_done_lat", done_cyc - mark_cyc, 1);

    // Good response, card never leaves busy
    cfg_good(1'b1, 1'b0, 1);
    seq_bits = '{0, 0, 1, 0, 1}; miso_tail = 1'b0; mark_rx = 5 + BT - 1;
    run_block(6000);
    check("t6_err", err_at_done, 3'd4);
    check("t6_status", stat_at_done, 3'b010);
    check("t6_done_lat", done_cyc - mark_cyc, 1);

    repeat (3) @(negedge clk);
    check("t6_err_held", {errCode, respStatus}, {3'd4, 3'b010});
    resetN = 1'b0;
    #1;
    check("idle_reset_clears", {errCode, respStatus}, 6'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Reset during data byte 200, then a clean block
    cfg_good(1'b1, 1'b0, 1);
    abort_tx = 8 + 200 * 8;
    run_block(3000);
    check("t7_aborted", aborted, 1'b1);
    repeat (2) @(negedge clk);
    check("t7_csn_in_reset", csN, 1'b1);
    resetN = 1'b1;
    cfg_good(1'b1, 1'b0, 1);
    run_block(6000);
    check_stream(16'h7FA1);
    check("t8_err", err_at_done, 3'd0);
    check("t8_status", stat_at_done, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
